// File: rtl/axi_burst_cmd_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_burst_cmd_seq: queues burst commands, issues them one at a time to the |
// | AXI Master, snoops R/B completion and returns one response each. Rev 1.0   |
// +----------------------------------------------------------------------------+
module axi_burst_cmd_seq #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic [7:0]   cmd_addr,
  input  logic [3:0]   cmd_len,
  input  logic [3:0]   cmd_id,
  input  logic [127:0] cmd_wdata,
  output logic         en,
  output logic         en_,
  output logic [15:0]  tb_R,
  output logic [15:0]  tb_W,
  output logic [127:0] INDATA,
  input  logic         RVALID,
  input  logic         RREADY,
  input  logic         RLAST,
  input  logic [7:0]   RDATA,
  input  logic         BVALID,
  input  logic         BREADY,
  input  logic [4:0]   BRESP,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_write,
  output logic [3:0]   rsp_id,
  output logic [127:0] rsp_rdata,
  output logic [4:0]   rsp_bresp,
  output logic         rsp_err
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              EW       = 145;
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]      TMO      = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT_R = 3'd2,
    S_WAIT_B = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  logic [EW-1:0]  mem_q [DEPTH];
  logic [EW-1:0]  mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  state_t         state_q, state_d;
  logic           en_r_q, en_r_d, en_w_q, en_w_d;
  logic [15:0]    tb_r_q, tb_r_d, tb_w_q, tb_w_d;
  logic [127:0]   indata_q, indata_d, rdata_q, rdata_d;
  logic [7:0]     timer_q, timer_d;
  logic [4:0]     beat_q, beat_d, beat_nx;
  logic [3:0]     len_q, len_d;
  logic [4:0]     bresp_q, bresp_d;
  logic           rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d, rsp_err_q, rsp_err_d;
  logic [3:0]     rsp_id_q, rsp_id_d;

  logic           do_push, do_pop, empty, full;
  logic           head_write;
  logic [7:0]     head_addr;
  logic [3:0]     head_len, head_id;
  logic [127:0]   head_wdata;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = (state_q == S_IDLE) && !empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign cmd_ready = !rst && (!full || do_pop);
  assign do_push = cmd_valid && cmd_ready;
  assign {head_write, head_addr, head_len, head_id, head_wdata} = mem_q[rd_ptr_q];

  assign en        = en_r_q;
  assign en_       = en_w_q;
  assign tb_R      = tb_r_q;
  assign tb_W      = tb_w_q;
  assign INDATA    = indata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rdata_q;
  assign rsp_bresp = bresp_q;
  assign rsp_err   = rsp_err_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    en_r_d      = 1'b0;
    en_w_d      = 1'b0;
    tb_r_d      = tb_r_q;
    tb_w_d      = tb_w_q;
    indata_d    = indata_q;
    rdata_d     = rdata_q;
    timer_d     = timer_q;
    beat_d      = beat_q;
    beat_nx     = beat_q;
    len_d       = len_q;
    bresp_d     = bresp_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_err_d   = rsp_err_q;
    rsp_id_d    = rsp_id_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = {cmd_write, cmd_addr, cmd_len, cmd_id, cmd_wdata};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          rsp_write_d = head_write;
          rsp_id_d    = head_id;
          len_d       = head_len;
          rdata_d     = '0;
          bresp_d     = '0;
          beat_d      = '0;
          timer_d     = '0;
          rsp_err_d   = 1'b0;
          if (head_len == 4'd0) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = S_ISSUE;
            if (head_write) begin
              en_w_d   = 1'b1;
              tb_w_d   = {head_addr, head_len, head_id};
              indata_d = head_wdata;
            end else begin
              en_r_d = 1'b1;
              tb_r_d = {head_addr, head_len, head_id};
            end
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = rsp_write_q ? S_WAIT_B : S_WAIT_R;
      end
      S_WAIT_R: begin
        timer_d = timer_q + 8'd1;
        if (RVALID && RREADY) begin
          // Beat counter saturates at 16, so any overrun also mismatches len.
          if (!beat_q[4]) begin
            rdata_d[{beat_q[3:0], 3'b000} +: 8] = RDATA;
            beat_nx = beat_q + 5'd1;
          end
          beat_d = beat_nx;
          if (RLAST) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = (beat_nx != {1'b0, len_q});
          end
        end
        if (state_d == S_WAIT_R && timer_q == TMO) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      S_WAIT_B: begin
        timer_d = timer_q + 8'd1;
        if (BVALID && BREADY) begin
          bresp_d     = BRESP;
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
        end else if (timer_q == TMO) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          tb_r_d      = '0;
          tb_w_d      = '0;
          indata_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_IDLE;
      en_r_q      <= 1'b0;
      en_w_q      <= 1'b0;
      tb_r_q      <= '0;
      tb_w_q      <= '0;
      indata_q    <= '0;
      rdata_q     <= '0;
      timer_q     <= '0;
      beat_q      <= '0;
      len_q       <= '0;
      bresp_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      en_r_q      <= en_r_d;
      en_w_q      <= en_w_d;
      tb_r_q      <= tb_r_d;
      tb_w_q      <= tb_w_d;
      indata_q    <= indata_d;
      rdata_q     <= rdata_d;
      timer_q     <= timer_d;
      beat_q      <= beat_d;
      len_q       <= len_d;
      bresp_q     <= bresp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_err_q   <= rsp_err_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

endmodule
`default_nettype wire
